rv_mc_core: RTL and testbench

RV_MC_CORE -- requirements
Module: rv_mc_core

---
 rtl/rv_mc_core.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_rv_mc_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mc_core.sv
// rtl/rv_mc_core.sv - multicycle RV32I/RV32E core with a single blocking memory port
module rv_mc_core #(
    parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
    parameter int          NUM_REGS         = 32,
    parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] memReadData,
    input  logic        memReady,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic [3:0]  byteMask,
    output logic        memRead,
    output logic        memWrite,
    output logic        trap,
    output logic [1:0]  trapCause
);

    localparam int RAW = (NUM_REGS == 16) ? 4 : 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
    localparam logic [1:0] CAUSE_MISDATA  = 2'b01;
    localparam logic [1:0] CAUSE_MISJUMP  = 2'b10;
    localparam logic [1:0] CAUSE_ENV      = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t      state;
    logic [31:0] pc, oldpc, ir;
    logic [31:0] rs1v, rs2v, result;
    logic [31:0] regs [NUM_REGS];

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = ir[6:0];
    assign rd_f  = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1_f = ir[19:15];
    assign rs2_f = ir[24:20];
    assign f7    = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : regs[idx[RAW-1:0]];
    endfunction

    // Decode legality; register-index checks only cover fields the format uses
    logic illegal, is_env, use_rs1, use_rs2, use_rd, bad_idx;

    always_comb begin
        illegal = 1'b0;
        is_env  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: use_rd = 1'b1;
            OP_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                illegal = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = (f3 > 3'b010);
            end
            OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                illegal = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                          ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OP_REG: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = !((f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_SYSTEM: begin
                is_env  = (ir == 32'h0000_0073) || (ir == 32'h0010_0073);
                illegal = !is_env;
            end
            default: illegal = 1'b1;
        endcase
        bad_idx = 1'b0;
        if (NUM_REGS == 16)
            bad_idx = (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]);
    end

    logic [31:0] alu_b, alu_out;
    logic [4:0]  shamt;

    always_comb begin
        alu_b = (opc == OP_REG) ? rs2v : imm_i;
        shamt = alu_b[4:0];
        case (f3)
            3'b000:  alu_out = ((opc == OP_REG) && f7[5]) ? rs1v - alu_b : rs1v + alu_b;
            3'b001:  alu_out = rs1v << shamt;
            3'b010:  alu_out = {31'd0, $signed(rs1v) < $signed(alu_b)};
            3'b011:  alu_out = {31'd0, rs1v < alu_b};
            3'b100:  alu_out = rs1v ^ alu_b;
            3'b101:  alu_out = f7[5] ? 32'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'b110:  alu_out = rs1v | alu_b;
            default: alu_out = rs1v & alu_b;
        endcase
    end

    logic taken;

    always_comb begin
        case (f3)
            3'b000:  taken = (rs1v == rs2v);
            3'b001:  taken = (rs1v != rs2v);
            3'b100:  taken = $signed(rs1v) < $signed(rs2v);
            3'b101:  taken = $signed(rs1v) >= $signed(rs2v);
            3'b110:  taken = rs1v < rs2v;
            3'b111:  taken = rs1v >= rs2v;
            default: taken = 1'b0;
        endcase
    end

    logic [31:0] br_target, jmp_target;

    assign br_target  = oldpc + imm_b;
    assign jmp_target = (opc == OP_JALR) ? ((rs1v + imm_i) & 32'hffff_fffe) : (oldpc + imm_j);

    // Load/store address, lane mask and store data; misaligned low bits are dropped
    // when the core is built not to trap on them
    logic [31:0] ls_addr, ls_eff, ls_wdata;
    logic [3:0]  ls_mask;
    logic        ls_misal;

    always_comb begin
        ls_addr  = rs1v + ((opc == OP_STORE) ? imm_s : imm_i);
        ls_misal = ((f3[1:0] == 2'b01) && ls_addr[0]) ||
                   ((f3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
        ls_eff   = ls_addr;
        if (ls_misal)
            ls_eff = (f3[1:0] == 2'b10) ? {ls_addr[31:2], 2'b00} : {ls_addr[31:1], 1'b0};
        case (f3[1:0])
            2'b00:   ls_mask = 4'b0001 << ls_eff[1:0];
            2'b01:   ls_mask = 4'b0011 << ls_eff[1:0];
            default: ls_mask = 4'b1111;
        endcase
        ls_wdata = rs2v << {ls_eff[1:0], 3'b000};
    end

    logic [31:0] ld_lane, ld_ext;

    always_comb begin
        ld_lane = memReadData >> {memAddress[1:0], 3'b000};
        case (f3)
            3'b000:  ld_ext = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'b001:  ld_ext = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'b100:  ld_ext = {24'd0, ld_lane[7:0]};
            3'b101:  ld_ext = {16'd0, ld_lane[15:0]};
            default: ld_ext = ld_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((state == S_WB) && (rd_f != 5'd0))
            regs[rd_f[RAW-1:0]] <= result;
    end

    // Every transition into FETCH raises the read request in the same edge, so a
    // fetch with memReady tied high costs exactly one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_FETCH;
            pc           <= RESET_VECTOR;
            oldpc        <= RESET_VECTOR;
            ir           <= 32'd0;
            rs1v         <= 32'd0;
            rs2v         <= 32'd0;
            result       <= 32'd0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
            memAddress   <= RESET_VECTOR;
            memWriteData <= 32'd0;
            byteMask     <= 4'b0000;
            trap         <= 1'b0;
            trapCause    <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!memRead) begin
                        memRead    <= 1'b1;
                        memAddress <= pc;
                        byteMask   <= 4'b1111;
                    end else if (memReady) begin
                        ir       <= memReadData;
                        oldpc    <= pc;
                        pc       <= pc + 32'd4;
                        memRead  <= 1'b0;
                        byteMask <= 4'b0000;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs1v <= rf_read(rs1_f);
                    rs2v <= rf_read(rs2_f);
                    if (illegal || bad_idx) begin
                        trap      <= 1'b1;
                        trapCause <= CAUSE_ILLEGAL;
                        state     <= S_TRAP;
                    end else if (is_env) begin
                        trap      <= 1'b1;
                        trapCause <= CAUSE_ENV;
                        state     <= S_TRAP;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opc)
                        OP_LUI: begin
                            result <= imm_u;
                            state  <= S_WB;
                        end
                        OP_AUIPC: begin
                            result <= oldpc + imm_u;
                            state  <= S_WB;
                        end
                        OP_IMM, OP_REG: begin
                            result <= alu_out;
                            state  <= S_WB;
                        end
                        OP_JAL, OP_JALR: begin
                            if (jmp_target[1]) begin
                                trap      <= 1'b1;
                                trapCause <= CAUSE_MISJUMP;
                                state     <= S_TRAP;
                            end else begin
                                pc     <= jmp_target;
                                result <= oldpc + 32'd4;
                                state  <= S_WB;
                            end
                        end
                        OP_BRANCH: begin
                            if (taken && br_target[1]) begin
                                trap      <= 1'b1;
                                trapCause <= CAUSE_MISJUMP;
                                state     <= S_TRAP;
                            end else begin
                                pc         <= taken ? br_target : pc;
                                memRead    <= 1'b1;
                                memAddress <= taken ? br_target : pc;
                                byteMask   <= 4'b1111;
                                state      <= S_FETCH;
                            end
                        end
                        OP_LOAD, OP_STORE: begin
                            if (ls_misal && TRAP_ON_MISALIGN) begin
                                trap      <= 1'b1;
                                trapCause <= CAUSE_MISDATA;
                                state     <= S_TRAP;
                            end else begin
                                memAddress <= ls_eff;
                                byteMask   <= ls_mask;
                                memRead    <= (opc == OP_LOAD);
                                memWrite   <= (opc == OP_STORE);
                                if (opc == OP_STORE)
                                    memWriteData <= ls_wdata;
                                state <= S_MEM;
                            end
                        end
                        default: begin
                            trap      <= 1'b1;
                            trapCause <= CAUSE_ILLEGAL;
                            state     <= S_TRAP;
                        end
                    endcase
                end
                S_MEM: begin
                    if (memReady) begin
                        memWrite <= 1'b0;
                        if (memWrite) begin
                            memRead    <= 1'b1;
                            memAddress <= pc;
                            byteMask   <= 4'b1111;
                            state      <= S_FETCH;
                        end else begin
                            memRead  <= 1'b0;
                            byteMask <= 4'b0000;
                            result   <= ld_ext;
                            state    <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    memRead    <= 1'b1;
                    memAddress <= pc;
                    byteMask   <= 4'b1111;
                    state      <= S_FETCH;
                end
                S_TRAP: begin
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                end
                default: state <= S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mc_core.sv
// tb/tb_rv_mc_core.sv - directed bench for rv_mc_core
module tb_rv_mc_core;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          both_seen = 1'b0;

    logic        reset_n_a = 1'b0, reset_n_b = 1'b0;
    logic        ready_a = 1'b1, ready_b = 1'b1;
    logic [31:0] rdata_a, rdata_b, addr_a, addr_b, wdata_a, wdata_b;
    logic [3:0]  mask_a, mask_b;
    logic        rd_a, rd_b, wr_a, wr_b, trap_a, trap_b;
    logic [1:0]  cause_a, cause_b;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic        poke_we_a = 1'b0, poke_we_b = 1'b0;
    logic [31:0] poke_addr = 32'd0, poke_data = 32'd0;

    localparam logic [31:0] JSELF  = 32'h0000_006f;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_mc_core #(.RESET_VECTOR(32'h100), .NUM_REGS(32), .TRAP_ON_MISALIGN(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n_a), .memReadData(rdata_a), .memReady(ready_a),
        .memAddress(addr_a), .memWriteData(wdata_a), .byteMask(mask_a),
        .memRead(rd_a), .memWrite(wr_a), .trap(trap_a), .trapCause(cause_a));

    rv_mc_core #(.RESET_VECTOR(32'h100), .NUM_REGS(16), .TRAP_ON_MISALIGN(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .memReadData(rdata_b), .memReady(ready_b),
        .memAddress(addr_b), .memWriteData(wdata_b), .byteMask(mask_b),
        .memRead(rd_b), .memWrite(wr_b), .trap(trap_b), .trapCause(cause_b));

    assign rdata_a = mem_a[addr_a[11:2]];
    assign rdata_b = mem_b[addr_b[11:2]];

    always @(posedge clk) begin
        if (poke_we_a)
            mem_a[poke_addr[11:2]] <= poke_data;
        else if (wr_a && ready_a)
            for (int i = 0; i < 4; i++)
                if (mask_a[i]) mem_a[addr_a[11:2]][8*i +: 8] <= wdata_a[8*i +: 8];
        if (poke_we_b)
            mem_b[poke_addr[11:2]] <= poke_data;
        else if (wr_b && ready_b)
            for (int i = 0; i < 4; i++)
                if (mask_b[i]) mem_b[addr_b[11:2]][8*i +: 8] <= wdata_b[8*i +: 8];
    end

    always @(negedge clk) begin
        if ((rd_a && wr_a) || (rd_b && wr_b)) both_seen = 1'b1;
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic poke(input bit sel, input logic [31:0] a, input logic [31:0] d);
        poke_addr = a;
        poke_data = d;
        if (sel) poke_we_b = 1'b1; else poke_we_a = 1'b1;
        @(negedge clk);
        poke_we_a = 1'b0;
        poke_we_b = 1'b0;
    endtask

    task automatic hold_reset(input bit sel);
        @(negedge clk);
        if (sel) begin reset_n_b = 1'b0; ready_b = 1'b1; end
        else     begin reset_n_a = 1'b0; ready_a = 1'b1; end
    endtask

    task automatic release_reset(input bit sel);
        @(negedge clk);
        if (sel) reset_n_b = 1'b1; else reset_n_a = 1'b1;
    endtask

    task automatic wait_fetch(input bit sel, input logic [31:0] a, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (sel ? (rd_b && addr_b == a) : (rd_a && addr_a == a)) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (rd_a !== 1'b0) begin miscompares++; $display("FAIL rst_memRead got=%b exp=0", rd_a); end
        vectors++; if (wr_a !== 1'b0) begin miscompares++; $display("FAIL rst_memWrite got=%b exp=0", wr_a); end
        vectors++; if (addr_a !== 32'h100) begin miscompares++; $display("FAIL rst_memAddress got=%h exp=00000100", addr_a); end
        vectors++; if (mask_a !== 4'b0000) begin miscompares++; $display("FAIL rst_byteMask got=%b exp=0000", mask_a); end
        vectors++; if (wdata_a !== 32'd0) begin miscompares++; $display("FAIL rst_memWriteData got=%h exp=0", wdata_a); end
        vectors++; if (trap_a !== 1'b0 || cause_a !== 2'b00) begin miscompares++; $display("FAIL rst_trap got=%b/%b exp=0/00", trap_a, cause_a); end
    endtask

    task automatic test_alu();
        bit ok;
        hold_reset(0);
        poke(0, 32'h100, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13));
        poke(0, 32'h104, enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2));
        poke(0, 32'h108, enc_s(12'h300, 5'd2, 5'd0, 3'b010));
        poke(0, 32'h10c, enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'h13));
        poke(0, 32'h110, enc_s(12'h304, 5'd0, 5'd0, 3'b010));
        poke(0, 32'h114, JSELF);
        poke(0, 32'h304, 32'hffff_ffff);
        release_reset(0);
        wait_fetch(0, 32'h100, 5, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL alu_first_fetch got=%h exp=00000100", addr_a); end
        repeat (4) @(negedge clk);
        vectors++; if (!(rd_a && addr_a == 32'h104)) begin miscompares++; $display("FAIL alu_fetch2_at4 got=%b/%h exp=1/00000104", rd_a, addr_a); end
        repeat (4) @(negedge clk);
        vectors++; if (!(rd_a && addr_a == 32'h108)) begin miscompares++; $display("FAIL alu_fetch3_at8 got=%b/%h exp=1/00000108", rd_a, addr_a); end
        wait_fetch(0, 32'h114, 40, ok);
        vectors++; if (mem_a[32'h300 >> 2] !== 32'd10) begin miscompares++; $display("FAIL alu_x2 got=%h exp=0000000a", mem_a[32'h300 >> 2]); end
        vectors++; if (mem_a[32'h304 >> 2] !== 32'd0) begin miscompares++; $display("FAIL alu_x0_zero got=%h exp=00000000", mem_a[32'h304 >> 2]); end
    endtask

    task automatic test_byte_lanes();
        bit ok;
        hold_reset(0);
        poke(0, 32'h100, enc_i(12'h0ab, 5'd0, 3'b000, 5'd1, 7'h13));
        poke(0, 32'h104, enc_s(12'h203, 5'd1, 5'd0, 3'b000));
        poke(0, 32'h108, enc_i(12'h203, 5'd0, 3'b000, 5'd3, 7'h03));
        poke(0, 32'h10c, enc_i(12'h203, 5'd0, 3'b100, 5'd4, 7'h03));
        poke(0, 32'h110, enc_s(12'h300, 5'd3, 5'd0, 3'b010));
        poke(0, 32'h114, enc_s(12'h304, 5'd4, 5'd0, 3'b010));
        poke(0, 32'h118, JSELF);
        poke(0, 32'h200, 32'h1122_3344);
        release_reset(0);
        for (int i = 0; i < 20 && !wr_a; i++) @(negedge clk);
        vectors++; if (!(wr_a && !rd_a && addr_a == 32'h203)) begin miscompares++; $display("FAIL sb_addr got=%b/%h exp=1/00000203", wr_a, addr_a); end
        vectors++; if (mask_a !== 4'b1000) begin miscompares++; $display("FAIL sb_mask got=%b exp=1000", mask_a); end
        vectors++; if (wdata_a !== 32'hab00_0000) begin miscompares++; $display("FAIL sb_wdata got=%h exp=ab000000", wdata_a); end
        wait_fetch(0, 32'h118, 60, ok);
        vectors++; if (mem_a[32'h200 >> 2] !== 32'hab22_3344) begin miscompares++; $display("FAIL sb_merge got=%h exp=ab223344", mem_a[32'h200 >> 2]); end
        vectors++; if (mem_a[32'h300 >> 2] !== 32'hffff_ffab) begin miscompares++; $display("FAIL lb_sext got=%h exp=ffffffab", mem_a[32'h300 >> 2]); end
        vectors++; if (mem_a[32'h304 >> 2] !== 32'h0000_00ab) begin miscompares++; $display("FAIL lbu_zext got=%h exp=000000ab", mem_a[32'h304 >> 2]); end
    endtask

    task automatic test_load_stall();
        bit ok;
        bit stable;
        int t0;
        hold_reset(0);
        poke(0, 32'h100, enc_i(12'h200, 5'd0, 3'b010, 5'd5, 7'h03));
        poke(0, 32'h104, enc_s(12'h308, 5'd5, 5'd0, 3'b010));
        poke(0, 32'h108, JSELF);
        poke(0, 32'h200, 32'hdead_beef);
        release_reset(0);
        wait_fetch(0, 32'h100, 5, ok);
        t0 = cyc;
        wait_fetch(0, 32'h200, 10, ok);
        ready_a = 1'b0;
        vectors++; if (!(ok && cyc - t0 == 3)) begin miscompares++; $display("FAIL lw_mem_start got=%0d exp=3", cyc - t0); end
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!(rd_a && !wr_a && addr_a == 32'h200 && mask_a == 4'b1111)) stable = 1'b0;
            @(negedge clk);
        end
        ready_a = 1'b1;
        vectors++; if (stable !== 1'b1) begin miscompares++; $display("FAIL lw_stall_stable got=%b exp=1", stable); end
        wait_fetch(0, 32'h104, 10, ok);
        vectors++; if (!(ok && cyc - t0 == 8)) begin miscompares++; $display("FAIL lw_stall_latency got=%0d exp=8", cyc - t0); end
        wait_fetch(0, 32'h108, 20, ok);
        vectors++; if (mem_a[32'h308 >> 2] !== 32'hdead_beef) begin miscompares++; $display("FAIL lw_data got=%h exp=deadbeef", mem_a[32'h308 >> 2]); end
    endtask

    task automatic test_branch();
        bit ok;
        bit seen;
        int t0;
        hold_reset(0);
        poke(0, 32'h100, enc_b(13'd8, 5'd0, 5'd0, 3'b000));
        poke(0, 32'h104, 32'd0);
        poke(0, 32'h108, JSELF);
        release_reset(0);
        wait_fetch(0, 32'h100, 5, ok);
        t0 = cyc;
        wait_fetch(0, 32'h108, 10, ok);
        vectors++; if (!(ok && cyc - t0 == 3)) begin miscompares++; $display("FAIL beq_taken got=%b/%0d exp=1/3", ok, cyc - t0); end
        hold_reset(0);
        poke(0, 32'h100, enc_b(13'd8, 5'd0, 5'd0, 3'b001));
        poke(0, 32'h104, JSELF);
        release_reset(0);
        wait_fetch(0, 32'h100, 5, ok);
        t0 = cyc;
        wait_fetch(0, 32'h104, 10, ok);
        vectors++; if (!(ok && cyc - t0 == 3 && !trap_a)) begin miscompares++; $display("FAIL bne_not_taken got=%b/%0d exp=1/3", ok, cyc - t0); end
        hold_reset(0);
        poke(0, 32'h100, enc_b(13'd6, 5'd0, 5'd0, 3'b000));
        release_reset(0);
        wait_fetch(0, 32'h100, 5, ok);
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rd_a || wr_a) seen = 1'b1;
            @(negedge clk);
        end
        vectors++; if (!(trap_a && cause_a == 2'b10 && !seen)) begin miscompares++; $display("FAIL beq_misaligned got=%b/%b/%b exp=1/10/0", trap_a, cause_a, seen); end
    endtask

    task automatic test_misalign();
        bit ok;
        bit seen;
        hold_reset(0);
        poke(0, 32'h100, enc_i(12'h202, 5'd0, 3'b010, 5'd6, 7'h03));
        release_reset(0);
        wait_fetch(0, 32'h100, 5, ok);
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rd_a || wr_a) seen = 1'b1;
            @(negedge clk);
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL lw_mis_no_request got=%b exp=0", seen); end
        vectors++; if (!(trap_a === 1'b1 && cause_a === 2'b01)) begin miscompares++; $display("FAIL lw_mis_trap got=%b/%b exp=1/01", trap_a, cause_a); end

        hold_reset(1);
        poke(1, 32'h100, enc_i(12'h202, 5'd0, 3'b010, 5'd6, 7'h03));
        poke(1, 32'h104, enc_s(12'h30c, 5'd6, 5'd0, 3'b010));
        poke(1, 32'h108, JSELF);
        poke(1, 32'h200, 32'hcafe_f00d);
        release_reset(1);
        wait_fetch(1, 32'h100, 5, ok);
        repeat (3) @(negedge clk);
        vectors++; if (!(rd_b && addr_b == 32'h200 && mask_b == 4'b1111)) begin miscompares++; $display("FAIL lw_forced_align got=%b/%h exp=1/00000200", rd_b, addr_b); end
        wait_fetch(1, 32'h108, 20, ok);
        vectors++; if (!(mem_b[32'h30c >> 2] === 32'hcafe_f00d && !trap_b)) begin miscompares++; $display("FAIL lw_forced_data got=%h exp=cafef00d", mem_b[32'h30c >> 2]); end
    endtask

    task automatic test_rv32e_traps();
        logic [31:0] prog [3];
        logic [1:0]  cause [3];
        bit          ok;
        bit          seen;
        prog[0] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd20); cause[0] = 2'b00;
        prog[1] = EBREAK;                                  cause[1] = 2'b11;
        prog[2] = enc_i(12'h102, 5'd0, 3'b000, 5'd1, 7'h67); cause[2] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            hold_reset(1);
            poke(1, 32'h100, prog[k]);
            release_reset(1);
            wait_fetch(1, 32'h100, 5, ok);
            @(negedge clk);
            for (int i = 0; i < 10 && !trap_b; i++) @(negedge clk);
            vectors++; if (!(trap_b === 1'b1 && cause_b === cause[k])) begin miscompares++; $display("FAIL e_trap_%0d got=%b/%b exp=1/%b", k, trap_b, cause_b, cause[k]); end
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (rd_b || wr_b) seen = 1'b1;
                @(negedge clk);
            end
            vectors++; if (!(seen === 1'b0 && trap_b === 1'b1 && cause_b === cause[k])) begin miscompares++; $display("FAIL e_frozen_%0d got=%b/%b exp=0/1", k, seen, trap_b); end
        end
    endtask

    task automatic test_reset_mid_store();
        bit ok;
        hold_reset(0);
        poke(0, 32'h100, enc_s(12'h300, 5'd0, 5'd0, 3'b010));
        poke(0, 32'h300, 32'h5555_5555);
        release_reset(0);
        for (int i = 0; i < 10 && !wr_a; i++) @(negedge clk);
        ready_a = 1'b0;
        vectors++; if (wr_a !== 1'b1) begin miscompares++; $display("FAIL mid_store_started got=%b exp=1", wr_a); end
        @(negedge clk);
        #2 reset_n_a = 1'b0;
        #1;
        vectors++; if (!(wr_a === 1'b0 && rd_a === 1'b0)) begin miscompares++; $display("FAIL mid_store_drop got=%b/%b exp=0/0", wr_a, rd_a); end
        vectors++; if (!(addr_a === 32'h100 && trap_a === 1'b0)) begin miscompares++; $display("FAIL mid_store_state got=%h/%b exp=00000100/0", addr_a, trap_a); end
        @(negedge clk);
        ready_a = 1'b1;
        release_reset(0);
        @(negedge clk);
        vectors++; if (!(rd_a && addr_a == 32'h100)) begin miscompares++; $display("FAIL mid_store_refetch got=%b/%h exp=1/00000100", rd_a, addr_a); end
        wait_fetch(0, 32'h100, 5, ok);
        vectors++; if (mem_a[32'h300 >> 2] !== 32'h5555_5555) begin miscompares++; $display("FAIL mid_store_no_write got=%h exp=55555555", mem_a[32'h300 >> 2]); end
        hold_reset(0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_byte_lanes();
        test_load_stall();
        test_branch();
        test_misalign();
        test_rv32e_traps();
        test_reset_mid_store();
        vectors++; if (both_seen !== 1'b0) begin miscompares++; $display("FAIL read_write_exclusive got=%b exp=0", both_seen); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
